// File: rtl/bot_motor_arbiter.sv
// Round-robin motor drive sequencer: one-hot drive, minimum hold, forced dead gap.
// Optional macro BOT_MOTOR_OPPOSE_EN: opposing requests (up/down, right/left) cancel.
module bot_motor_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [3:0] motor,
  output logic [1:0] cur_dir,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic [CNT_W-1:0] dead_cnt, dead_nx;
  logic [3:0]       motor_nx;
  logic [1:0]       dir_nx;
  logic [3:0]       req_eff;
  logic [1:0]       winner;
  logic             any_req;
  logic [7:0]       req_dbl;
  logic [3:0]       req_rot;

  always_comb begin
    req_eff = req;
`ifdef BOT_MOTOR_OPPOSE_EN
    if (req[0] && req[2]) begin
      req_eff[0] = 1'b0;
      req_eff[2] = 1'b0;
    end
    if (req[1] && req[3]) begin
      req_eff[1] = 1'b0;
      req_eff[3] = 1'b0;
    end
`endif
  end

  assign any_req = |req_eff;

  // Rotate so bit 0 is the direction just after the last grant; lowest set bit wins.
  always_comb begin
    req_dbl = {req_eff, req_eff} >> (3'(cur_dir) + 3'd1);
    req_rot = req_dbl[3:0];
    winner  = cur_dir;
    for (int j = 3; j >= 0; j--) begin
      if (req_rot[j]) winner = cur_dir + 2'd1 + 2'(j);
    end
  end

  always_comb begin
    state_nx = state;
    motor_nx = motor;
    dir_nx   = cur_dir;
    hold_nx  = hold_cnt;
    dead_nx  = dead_cnt;
    case (state)
      IDLE: begin
        motor_nx = '0;
        if (enable && any_req) begin
          state_nx = DRIVE;
          motor_nx = 4'b0001 << winner;
          dir_nx   = winner;
          hold_nx  = '0;
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_nx = DEAD;
          motor_nx = '0;
          dead_nx  = '0;
        end else if (hold_cnt < HOLD_LAST) begin
          hold_nx = hold_cnt + CNT_W'(1);
        end else if (req_eff != motor) begin
          // Owner alone keeps the drive; any other requester (or none) ends it.
          state_nx = DEAD;
          motor_nx = '0;
          dead_nx  = '0;
        end
      end
      DEAD: begin
        motor_nx = '0;
        if (dead_cnt < DEAD_LAST) begin
          dead_nx = dead_cnt + CNT_W'(1);
        end else if (enable && any_req) begin
          state_nx = DRIVE;
          motor_nx = 4'b0001 << winner;
          dir_nx   = winner;
          hold_nx  = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        motor_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      motor    <= '0;
      cur_dir  <= 2'd3;
      busy     <= 1'b0;
      hold_cnt <= '0;
      dead_cnt <= '0;
    end else begin
      state    <= state_nx;
      motor    <= motor_nx;
      cur_dir  <= dir_nx;
      busy     <= (state_nx != IDLE);
      hold_cnt <= hold_nx;
      dead_cnt <= dead_nx;
    end
  end

endmodule

// File: tb/tb_bot_motor_arbiter.sv
// Self-checking bench for bot_motor_arbiter: directed scenarios plus random stimulus
// against a cycle-count model of the drive/dead/idle rules.
module tb_bot_motor_arbiter;
  localparam int HOLD = 4;
  localparam int DEAD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] motor;
  logic [1:0] cur_dir;
  logic       busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  bot_motor_arbiter #(.HOLD_CYCLES(HOLD), .DEAD_CYCLES(DEAD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .motor(motor), .cur_dir(cur_dir), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] eff(input logic [3:0] r);
    logic [3:0] e;
    e = r;
`ifdef BOT_MOTOR_OPPOSE_EN
    if (r[0] && r[2]) begin e[0] = 1'b0; e[2] = 1'b0; end
    if (r[1] && r[3]) begin e[1] = 1'b0; e[3] = 1'b0; end
`endif
    return e;
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  // Model: mode 0 idle, 1 driving (held = cycles driven so far), 2 gap (gap = zero cycles so far)
  int         m_mode = 0;
  int         m_ptr = 3;
  int         m_held = 0;
  int         m_gap = 0;
  logic [3:0] m_motor = '0;
  logic [3:0] m_re;
  int         m_pick;

  always_comb m_re = eff(req);
  always_comb m_pick = pick(m_re, m_ptr);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode <= 0; m_ptr <= 3; m_motor <= '0; m_held <= 0; m_gap <= 0;
    end else if (m_mode == 0) begin
      if (enable && m_re != 0) begin
        m_mode <= 1; m_ptr <= m_pick; m_held <= 1; m_motor <= 4'(1 << m_pick);
      end
    end else if (m_mode == 1) begin
      if (!enable || (m_held >= HOLD && m_re != 4'(1 << m_ptr))) begin
        m_mode <= 2; m_gap <= 1; m_motor <= '0;
      end else if (m_held < HOLD) begin
        m_held <= m_held + 1;
      end
    end else begin
      if (m_gap < DEAD) m_gap <= m_gap + 1;
      else if (enable && m_re != 0) begin
        m_mode <= 1; m_ptr <= m_pick; m_held <= 1; m_motor <= 4'(1 << m_pick);
      end else m_mode <= 0;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_motor", 8'(motor), 8'(m_motor));
      check("model_cur_dir", 8'(cur_dir), 8'(m_ptr));
      check("model_busy", 8'(busy), 8'(m_mode != 0));
      check("onehot", 8'($countones(motor) <= 1), 8'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; enable = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    rst_n = 1'b1;
  endtask

  localparam logic [3:0] T2 [7]  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2};
  localparam logic [3:0] T3 [13] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                                     4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h4};

  initial begin
    // Reset state
    do_reset();
    check("rst_motor", 8'(motor), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_cur_dir", 8'(cur_dir), 8'h3);

    // 1: single up request is granted and held
    req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t1_motor", 8'(motor), 8'h1);
      check("t1_busy", 8'(busy), 8'h1);
      check("t1_cur_dir", 8'(cur_dir), 8'h0);
    end

    // 2: right joins one cycle after grant -> hold, gap, then right
    do_reset();
    req = 4'b0001;
    tick();
    check("t2_seq", 8'(motor), 8'(T2[0]));
    req = 4'b0011;
    for (int i = 1; i < 7; i++) begin
      tick();
      check("t2_seq", 8'(motor), 8'(T2[i]));
    end
    check("t2_cur_dir", 8'(cur_dir), 8'h1);

`ifndef BOT_MOTOR_OPPOSE_EN
    // 3: all requesting -> rotation with hold and gap
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      tick();
      check("t3_seq", 8'(motor), 8'(T3[i]));
    end
`endif

    // 4: enable drop on second drive cycle
    do_reset();
    req = 4'b0001;
    tick(); check("t4_e1", 8'(motor), 8'h1);
    tick(); check("t4_e2", 8'(motor), 8'h1);
    enable = 1'b0;
    tick(); check("t4_e3", 8'(motor), 8'h0);
    check("t4_busy_dead", 8'(busy), 8'h1);
    tick(); check("t4_e4", 8'(motor), 8'h0);
    check("t4_busy_dead2", 8'(busy), 8'h1);
    tick(); check("t4_e5", 8'(motor), 8'h0);
    check("t4_busy_idle", 8'(busy), 8'h0);
    enable = 1'b1;

    // 5: reset mid-drive, then re-grant right after release
    do_reset();
    req = 4'b0100;
    tick(); check("t5_grant", 8'(motor), 8'h4);
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_rst_motor", 8'(motor), 8'h0);
    check("t5_rst_busy", 8'(busy), 8'h0);
    check("t5_rst_dir", 8'(cur_dir), 8'h3);
    rst_n = 1'b1;
    tick();
    check("t5_regrant", 8'(motor), 8'h4);
    check("t5_regrant_dir", 8'(cur_dir), 8'h2);

    // 6: up and down together
    do_reset();
    req = 4'b0101;
`ifdef BOT_MOTOR_OPPOSE_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_cancel_motor", 8'(motor), 8'h0);
      check("t6_cancel_busy", 8'(busy), 8'h0);
    end
`else
    tick(); check("t6_first", 8'(motor), 8'h1);
    for (int i = 0; i < 6; i++) tick();
    check("t6_second", 8'(motor), 8'h4);
`endif

    // Random phase
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
        else req = 4'(1 << $urandom_range(0, 3));
      end
      enable = ($urandom_range(0, 29) != 0);
      rst_n  = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
